// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side scheduling logic.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RECFG     = 3'd4
  } tx_sched_state_t;

  // baud_controller rate codes
  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;
  localparam logic [2:0] BAUD_230400 = 3'd5;
  localparam logic [2:0] BAUD_460800 = 3'd6;
  localparam logic [2:0] BAUD_921600 = 3'd7;

  localparam int unsigned DEF_BUSY_TIMEOUT = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1.
module uart_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             vld
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IW'((32'(ptr) + i) % N_REQ);
      if (!vld && req[cand]) begin
        vld       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one uart_transmitter between N_REQ byte sources,
// with baud changes applied only between frames.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter logic [2:0]  BAUD_RESET   = BAUD_9600
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [8*N_REQ-1:0] REQ_DATA,
  output logic [N_REQ-1:0]   GNT,
  output logic [N_REQ-1:0]   DONE,
  output logic               ERR,
  input  logic               CFG_WR,
  input  logic [2:0]         CFG_BAUD,
  output logic [7:0]         Tx_DATA,
  output logic               Tx_WR,
  input  logic               Tx_BUSY,
  output logic               Tx_EN,
  output logic [2:0]         baud_select
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  tx_sched_state_t state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [IW-1:0]    win_q, win_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2:0]       baud_q, baud_d;
  logic [2:0]       pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             en_q;
  logic             err;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      win_q      <= '0;
      ptr_q      <= IW'(N_REQ - 1);
      data_q     <= '0;
      cnt_q      <= '0;
      baud_q     <= BAUD_RESET;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      win_q      <= win_d;
      ptr_q      <= ptr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      baud_q     <= baud_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      en_q       <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    win_d      = win_q;
    ptr_d      = ptr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    baud_d     = baud_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    err        = 1'b0;

    if (CFG_WR) begin
      pend_val_d = CFG_BAUD;
      pend_d     = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        // A same-cycle CFG_WR counts as pending so reconfiguration wins the tie.
        if (pend_q || CFG_WR) begin
          state_d = ST_RECFG;
        end else if (pick_vld) begin
          gnt_d = pick_gnt;
          win_d = pick_idx;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) data_d = REQ_DATA[8*i +: 8];
          end
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (Tx_BUSY) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == 8'(BUSY_TIMEOUT - 1)) begin
          err     = 1'b1;
          gnt_d   = '0;
          ptr_d   = win_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WAIT_DONE: begin
        // DONE is registered, so the state holds one extra cycle with GNT still high.
        if (done_q != '0) begin
          gnt_d   = '0;
          ptr_d   = win_q;
          state_d = ST_IDLE;
        end else if (!Tx_BUSY) begin
          done_d = gnt_q;
        end
      end
      ST_RECFG: begin
        baud_d  = pend_val_q;
        pend_d  = CFG_WR;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign GNT         = gnt_q;
  assign DONE        = done_q;
  assign ERR         = err;
  assign Tx_DATA     = data_q;
  assign Tx_WR       = (state_q == ST_LAUNCH);
  assign Tx_EN       = en_q && (state_q != ST_RECFG);
  assign baud_select = baud_q;

endmodule
